// File: rtl/qmfir_plb_master.sv
// qmfir_plb_master: single-beat PLB v4.6 master for qmfir sample fetch
// and result write-back; one 32-bit command in flight at a time.
module qmfir_plb_master #(
    parameter int         C_MPLB_AWIDTH        = 32,
    parameter int         C_MPLB_DWIDTH        = 128,
    parameter int         C_MPLB_NATIVE_DWIDTH = 32,
    parameter logic [0:1] C_MPLB_PRIORITY      = 2'b00,
    parameter             C_FAMILY             = "virtex5"
) (
    input  logic                              MPLB_Clk,
    input  logic                              MPLB_Rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_rnw,
    input  logic [0:C_MPLB_AWIDTH-1]          cmd_addr,
    input  logic [0:C_MPLB_NATIVE_DWIDTH-1]   cmd_wdata,
    input  logic [0:3]                        cmd_be,
    output logic                              rsp_valid,
    output logic [0:C_MPLB_NATIVE_DWIDTH-1]   rsp_rdata,
    output logic                              rsp_err,
    output logic                              M_request,
    output logic                              M_busLock,
    output logic                              M_RNW,
    output logic                              M_abort,
    output logic                              M_lockErr,
    output logic                              M_wrBurst,
    output logic                              M_rdBurst,
    output logic [0:1]                        M_priority,
    output logic [0:1]                        M_MSize,
    output logic [0:3]                        M_size,
    output logic [0:2]                        M_type,
    output logic [0:15]                       M_TAttribute,
    output logic [0:C_MPLB_AWIDTH-1]          M_ABus,
    output logic [0:31]                       M_UABus,
    output logic [0:15]                       M_BE,
    output logic [0:C_MPLB_DWIDTH-1]          M_wrDBus,
    input  logic                              PLB_MAddrAck,
    input  logic                              PLB_MRearbitrate,
    input  logic                              PLB_MTimeout,
    input  logic                              PLB_MBusy,
    input  logic                              PLB_MRdErr,
    input  logic                              PLB_MWrErr,
    input  logic                              PLB_MIRQ,
    input  logic [0:1]                        PLB_MSSize,
    input  logic [0:C_MPLB_DWIDTH-1]          PLB_MRdDBus,
    input  logic [0:3]                        PLB_MRdWdAddr,
    input  logic                              PLB_MRdDAck,
    input  logic                              PLB_MRdBTerm,
    input  logic                              PLB_MWrDAck,
    input  logic                              PLB_MWrBTerm
);

    localparam int AW = C_MPLB_AWIDTH;
    localparam int NW = C_MPLB_NATIVE_DWIDTH;
    localparam int LANES = C_MPLB_DWIDTH / C_MPLB_NATIVE_DWIDTH;
    localparam bit unusedFamily = (C_FAMILY == "virtex5");

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT_WR, WAIT_RD, BACKOFF, RESP
    } stateT;

    stateT state;
    stateT nextState;

    logic          rnwQ;
    logic [0:AW-1] addrQ;
    logic [0:NW-1] wdataQ;
    logic [0:3]    beQ;
    logic [0:NW-1] rdataQ;
    logic          errQ;
    logic [0:NW-1] rdLane;
    logic          cmdFire;
    logic          unusedInputs;

    assign unusedInputs = ^{PLB_MBusy, PLB_MIRQ, PLB_MRdWdAddr,
                            PLB_MRdBTerm, PLB_MWrBTerm,
                            addrQ[AW-2:AW-1], unusedFamily};

    assign cmdFire = cmd_valid && cmd_ready;

    // State register; reset aborts any transfer without a response.
    always_ff @(posedge MPLB_Clk) begin
        if (MPLB_Rst) state <= IDLE;
        else          state <= nextState;
    end

    // Next-state logic; timeout beats addrAck, addrAck beats rearbitrate.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (cmd_valid) nextState = REQ;
            REQ: begin
                if (PLB_MTimeout)          nextState = RESP;
                else if (PLB_MAddrAck)     nextState = rnwQ ? WAIT_RD : WAIT_WR;
                else if (PLB_MRearbitrate) nextState = BACKOFF;
            end
            BACKOFF: nextState = REQ;
            WAIT_WR: if (PLB_MWrDAck) nextState = RESP;
            WAIT_RD: if (PLB_MRdDAck) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Pick the read word: narrow slaves use lane 0, wide ones the addressed lane.
    always_comb begin
        rdLane = PLB_MRdDBus[0 +: NW];
        if (PLB_MSSize != 2'b00) begin
            case (addrQ[AW-4:AW-3])
                2'd0:    rdLane = PLB_MRdDBus[0 +: NW];
                2'd1:    rdLane = PLB_MRdDBus[NW +: NW];
                2'd2:    rdLane = PLB_MRdDBus[2*NW +: NW];
                default: rdLane = PLB_MRdDBus[3*NW +: NW];
            endcase
        end
    end

    // Command latch and response capture.
    always_ff @(posedge MPLB_Clk) begin
        if (MPLB_Rst) begin
            rnwQ   <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            beQ    <= '0;
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else begin
            if (cmdFire) begin
                rnwQ   <= cmd_rnw;
                addrQ  <= cmd_addr;
                wdataQ <= cmd_wdata;
                beQ    <= cmd_be;
            end
            if (state == REQ && PLB_MTimeout) begin
                errQ   <= 1'b1;
                rdataQ <= '0;
            end else if (state == WAIT_WR && PLB_MWrDAck) begin
                errQ   <= PLB_MWrErr;
                rdataQ <= '0;
            end else if (state == WAIT_RD && PLB_MRdDAck) begin
                errQ   <= PLB_MRdErr;
                rdataQ <= rdLane;
            end
        end
    end

    assign cmd_ready    = (state == IDLE) && !MPLB_Rst;
    assign rsp_valid    = (state == RESP);
    assign rsp_rdata    = rdataQ;
    assign rsp_err      = errQ;

    assign M_request    = (state == REQ) && !MPLB_Rst;
    assign M_RNW        = (state == REQ) ? rnwQ : 1'b0;
    assign M_ABus       = (state == REQ) ? {addrQ[0:AW-3], 2'b00} : '0;
    assign M_BE         = {beQ, 12'b0};
    assign M_wrDBus     = (state == WAIT_WR) ? {LANES{wdataQ}} : '0;

    assign M_busLock    = 1'b0;
    assign M_abort      = 1'b0;
    assign M_lockErr    = 1'b0;
    assign M_wrBurst    = 1'b0;
    assign M_rdBurst    = 1'b0;
    assign M_priority   = C_MPLB_PRIORITY;
    assign M_MSize      = 2'b00;
    assign M_size       = 4'b0000;
    assign M_type       = 3'b000;
    assign M_TAttribute = '0;
    assign M_UABus      = '0;

endmodule

// File: tb/tb_qmfir_plb_master.sv
// tb_qmfir_plb_master: scripted PLB slave plus response scoreboard
// for qmfir_plb_master.
module tb_qmfir_plb_master;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_rnw;
    logic [0:31]   cmd_addr, cmd_wdata;
    logic [0:3]    cmd_be;
    logic          rsp_valid, rsp_err;
    logic [0:31]   rsp_rdata;
    logic          M_request, M_busLock, M_RNW, M_abort, M_lockErr;
    logic          M_wrBurst, M_rdBurst;
    logic [0:1]    M_priority, M_MSize;
    logic [0:3]    M_size;
    logic [0:2]    M_type;
    logic [0:15]   M_TAttribute;
    logic [0:31]   M_ABus, M_UABus;
    logic [0:15]   M_BE;
    logic [0:127]  M_wrDBus;
    logic          addrAck, rearb, tmo, rdErr, wrErr, rdDAck, wrDAck;
    logic [0:1]    ssize;
    logic [0:127]  rdBus;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chkData;
    } expT;

    expT sbQ[$];
    int  checks = 0;
    int  failures = 0;
    int  rspCount = 0;

    always #5 clk = ~clk;

    qmfir_plb_master dut (
        .MPLB_Clk(clk), .MPLB_Rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_request(M_request), .M_busLock(M_busLock), .M_RNW(M_RNW),
        .M_abort(M_abort), .M_lockErr(M_lockErr), .M_wrBurst(M_wrBurst),
        .M_rdBurst(M_rdBurst), .M_priority(M_priority), .M_MSize(M_MSize),
        .M_size(M_size), .M_type(M_type), .M_TAttribute(M_TAttribute),
        .M_ABus(M_ABus), .M_UABus(M_UABus), .M_BE(M_BE), .M_wrDBus(M_wrDBus),
        .PLB_MAddrAck(addrAck), .PLB_MRearbitrate(rearb),
        .PLB_MTimeout(tmo), .PLB_MBusy(1'b0), .PLB_MRdErr(rdErr),
        .PLB_MWrErr(wrErr), .PLB_MIRQ(1'b0), .PLB_MSSize(ssize),
        .PLB_MRdDBus(rdBus), .PLB_MRdWdAddr(4'b0), .PLB_MRdDAck(rdDAck),
        .PLB_MRdBTerm(1'b0), .PLB_MWrDAck(wrDAck), .PLB_MWrBTerm(1'b0)
    );

    task automatic checkVal(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Response monitor: every rsp_valid pops one expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            expT e;
            rspCount++;
            if (sbQ.size() == 0) begin
                checkVal("unexpRsp", 1, 0);
            end else begin
                e = sbQ.pop_front();
                checkVal("rspErr", rsp_err, e.err);
                if (e.chkData) checkVal("rspData", rsp_rdata, e.data);
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic e, input bit c);
        expT x;
        x.data = d; x.err = e; x.chkData = c;
        sbQ.push_back(x);
    endtask

    // Called at a negedge; returns at the negedge of the first REQ cycle.
    task automatic issue(input logic rnw, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input bit hold);
        bit ok = 0;
        logic seen;
        cmd_valid = 1'b1; cmd_rnw = rnw;
        cmd_addr = a; cmd_wdata = d; cmd_be = be;
        for (int i = 0; i < 20; i++) begin
            seen = cmd_ready;
            @(negedge clk);
            if (seen === 1'b1) begin
                ok = 1;
                break;
            end
        end
        checkVal("handshake", ok, 1);
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Called in a REQ cycle; returns at the negedge of the RESP cycle.
    task automatic rdPhase(input logic [1:0] ss, input logic [127:0] bus,
                           input logic e);
        addrAck = 1'b1;
        @(negedge clk);
        addrAck = 1'b0;
        rdDAck = 1'b1; ssize = ss; rdBus = bus; rdErr = e;
        @(negedge clk);
        rdDAck = 1'b0; rdErr = 1'b0; rdBus = '0; ssize = 2'b00;
        checkVal("rdRspValid", rsp_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
        addrAck = 0; rearb = 0; tmo = 0; rdErr = 0; wrErr = 0;
        rdDAck = 0; wrDAck = 0; ssize = 2'b00; rdBus = '0;
        repeat (3) @(negedge clk);
        checkVal("rstReady", cmd_ready, 0);
        checkVal("rstReq", M_request, 0);
        checkVal("rstRsp", rsp_valid, 0);
        checkVal("rstABus", M_ABus, 0);
        checkVal("rstBE", M_BE, 0);
        checkVal("rstWrD", M_wrDBus, 0);
        checkVal("rstRdata", rsp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        checkVal("readyAfterRst", cmd_ready, 1);

        // Write with addrAck one cycle late, WrDAck two cycles after that.
        push(32'h0, 1'b0, 0);
        issue(1'b0, 32'hC1A20010, 32'hDEADBEEF, 4'hF, 0);
        checkVal("wrReq", M_request, 1);
        checkVal("wrABus", M_ABus, 32'hC1A20010);
        checkVal("wrRNW", M_RNW, 0);
        checkVal("wrBE", M_BE, 16'hF000);
        @(negedge clk);
        checkVal("wrReqHeld", M_request, 1);
        addrAck = 1'b1;
        @(negedge clk);
        addrAck = 1'b0;
        checkVal("wrReqDrop", M_request, 0);
        checkVal("wrDBus", M_wrDBus, {4{32'hDEADBEEF}});
        @(negedge clk);
        checkVal("wrDBusHeld", M_wrDBus, {4{32'hDEADBEEF}});
        wrDAck = 1'b1;
        @(negedge clk);
        wrDAck = 1'b0;
        checkVal("wrRspValid", rsp_valid, 1);
        checkVal("wrDBusOff", M_wrDBus, 0);
        @(negedge clk);

        // Read, wide slave, lane 3.
        push(32'h12345678, 1'b0, 1);
        issue(1'b1, 32'hC1A2000C, 32'h0, 4'hF, 0);
        checkVal("rdRNW", M_RNW, 1);
        checkVal("rdABus", M_ABus, 32'hC1A2000C);
        rdPhase(2'b10, {32'hAAAA0000, 32'hBBBB1111,
                        32'hCCCC2222, 32'h12345678}, 1'b0);
        @(negedge clk);

        // Read, narrow slave, word on lane 0.
        push(32'h12345678, 1'b0, 1);
        issue(1'b1, 32'hC1A2000C, 32'h0, 4'hF, 0);
        rdPhase(2'b00, {32'h12345678, 32'h0, 32'h0, 32'h55555555}, 1'b0);
        @(negedge clk);

        // Two rearbitrations before the address phase completes.
        push(32'hCAFEF00D, 1'b0, 1);
        issue(1'b1, 32'hC1A20004, 32'h0, 4'hF, 0);
        for (int k = 0; k < 2; k++) begin
            rearb = 1'b1;
            @(negedge clk);
            rearb = 1'b0;
            checkVal("backoffLow", M_request, 0);
            @(negedge clk);
            checkVal("retryHigh", M_request, 1);
        end
        rdPhase(2'b01, {32'h1, 32'hCAFEF00D, 32'h3, 32'h4}, 1'b0);
        @(negedge clk);

        // Timeout together with addrAck: timeout wins.
        push(32'h0, 1'b1, 0);
        issue(1'b0, 32'h00000010, 32'h5A5A5A5A, 4'hF, 0);
        tmo = 1'b1; addrAck = 1'b1;
        @(negedge clk);
        tmo = 1'b0; addrAck = 1'b0;
        checkVal("toRspValid", rsp_valid, 1);
        checkVal("toNoData", M_wrDBus, 0);
        @(negedge clk);

        // Read ending with a slave read error.
        push(32'h87654321, 1'b1, 1);
        issue(1'b1, 32'hC1A20008, 32'h0, 4'hF, 0);
        rdPhase(2'b10, {32'h0, 32'h0, 32'h87654321, 32'h0}, 1'b1);
        @(negedge clk);

        // Back-to-back: cmd_valid held across the first response.
        push(32'h0, 1'b0, 0);
        push(32'h0F0F0F0F, 1'b0, 1);
        issue(1'b0, 32'h00000100, 32'h11112222, 4'b0011, 1);
        cmd_rnw = 1'b1; cmd_addr = 32'h0000020C;
        addrAck = 1'b1;
        @(negedge clk);
        addrAck = 1'b0; wrDAck = 1'b1;
        @(negedge clk);
        wrDAck = 1'b0;
        checkVal("b2bRsp1", rsp_valid, 1);
        checkVal("b2bNoReadyInResp", cmd_ready, 0);
        @(negedge clk);
        checkVal("b2bReady", cmd_ready, 1);
        checkVal("b2bIdleReq", M_request, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkVal("b2bReq2", M_request, 1);
        checkVal("b2bABus2", M_ABus, 32'h0000020C);
        checkVal("b2bRNW2", M_RNW, 1);
        rdPhase(2'b10, {32'h0, 32'h0, 32'h0, 32'h0F0F0F0F}, 1'b0);
        @(negedge clk);

        // Reset pulsed while waiting for read data.
        issue(1'b1, 32'h00000040, 32'h0, 4'hF, 0);
        addrAck = 1'b1;
        @(negedge clk);
        addrAck = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkVal("midRstReq", M_request, 0);
        checkVal("midRstABus", M_ABus, 0);
        checkVal("midRstRNW", M_RNW, 0);
        checkVal("midRstBE", M_BE, 0);
        checkVal("midRstRsp", rsp_valid, 0);
        checkVal("midRstRdata", rsp_rdata, 0);
        checkVal("midRstReady", cmd_ready, 0);
        rst = 1'b0;
        rdDAck = 1'b1; ssize = 2'b10; rdBus = {4{32'hFFFF0000}};
        @(negedge clk);
        rdDAck = 1'b0; rdBus = '0; ssize = 2'b00;
        checkVal("lateAckNoRsp", rsp_valid, 0);
        checkVal("lateAckReady", cmd_ready, 1);
        @(negedge clk);
        checkVal("lateAckNoRsp2", rsp_valid, 0);

        repeat (2) @(negedge clk);
        checkVal("sbEmpty", sbQ.size(), 0);
        checkVal("rspCount", rspCount, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
